// File: rtl/sc_wrr_slave_arbiter.sv
// -----------------------------------------------------------------------------
// sc_wrr_slave_arbiter
//
// Weighted round-robin arbiter guarding one slave port of the single-cycle
// crossbar. One of NUM_MS masters holds the grant until the slave acks. A master
// may win up to its weight of back-to-back transactions before priority moves
// on to the next master.
//
// Optional feature macro: SC_WRR_ARB_TIMEOUT_EN
//   When defined, a watchdog releases a grant that sees no ack for TO_CYCLES
//   grant cycles and pulses o_timeout. When undefined, o_timeout is tied to 0
//   and a grant is held until ack or request drop.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_reset      synchronous active-high reset
//   i_ms_req     per-master request level
//   i_ms_weight  per-master weight, master k at [k*WEIGHT_W +: WEIGHT_W]
//   i_sl_ack     slave completion strobe for the current grant
//   o_ms_en      one-hot registered grant
//   o_grant_id   index of the granted master (valid while o_busy)
//   o_busy       a grant is active (also the FSM state: 1 = GRANT)
//   o_timeout    one-cycle pulse when the watchdog releases a grant
//
// Handshake: a master raises i_ms_req and keeps it high until it sees its
// o_ms_en bit fall. The slave completes the transaction by pulsing i_sl_ack for
// one cycle while o_busy is high; the grant ends on the following edge. Lowering
// i_ms_req during a grant without an ack aborts that grant. i_sl_ack is ignored
// while o_busy is low.
// -----------------------------------------------------------------------------
module sc_wrr_slave_arbiter #(
    parameter int  NUM_MS    = 4,
    parameter int  WEIGHT_W  = 3,
    parameter int  TO_CYCLES = 255,
    localparam int ID_W      = (NUM_MS > 1) ? $clog2(NUM_MS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_MS-1:0]          i_ms_req,
    input  logic [NUM_MS*WEIGHT_W-1:0] i_ms_weight,
    input  logic                       i_sl_ack,
    output logic [NUM_MS-1:0]          o_ms_en,
    output logic [ID_W-1:0]            o_grant_id,
    output logic                       o_busy,
    output logic                       o_timeout
);

    if (NUM_MS < 2) begin : g_bad_num_ms
        $error("sc_wrr_slave_arbiter: NUM_MS must be at least 2");
    end
    if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to_cycles
        $error("sc_wrr_slave_arbiter: TO_CYCLES must be in 1..255");
    end

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ID_W-1:0]     g_q, g_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q [NUM_MS];
    logic [WEIGHT_W-1:0] credit_d [NUM_MS];
    logic [NUM_MS-1:0]   ms_en_q, ms_en_d;

    logic [WEIGHT_W-1:0] weight_arr [NUM_MS];
    logic [ID_W-1:0]     sel;
    logic                sel_vld;
    logic [WEIGHT_W-1:0] reload_val;
    logic [WEIGHT_W-1:0] credit_dec;
    logic                to_hit;
    logic                abort;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_MS - 1)) begin
            return '0;
        end
        return id + ID_W'(1);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_MS; k++) begin
            weight_arr[k] = i_ms_weight[k*WEIGHT_W +: WEIGHT_W];
        end
    end

    // First requester at or after ptr, wrapping modulo NUM_MS. The sum is one
    // bit wider than an index so ptr + offset never overflows before the wrap.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        sel     = '0;
        sel_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_MS; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_MS)) begin
                sum = sum - (ID_W+1)'(NUM_MS);
            end
            idx = sum[ID_W-1:0];
            if (!sel_vld && i_ms_req[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    // A zero weight still grants one transaction per turn.
    assign reload_val = (weight_arr[sel] == '0) ? WEIGHT_W'(1) : weight_arr[sel];
    assign credit_dec = credit_q[g_q] - WEIGHT_W'(1);
    assign abort      = !i_ms_req[g_q] || to_hit;

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_d = ST_GRANT;
                    g_d     = sel;
                    // Leftover credit from an earlier burst is kept; only an
                    // exhausted master gets a fresh weight load.
                    if (credit_q[sel] == '0) begin
                        credit_d[sel] = reload_val;
                    end
                end
            end
            ST_GRANT: begin
                if (i_sl_ack) begin
                    // Ack wins over a same-cycle drop or watchdog expiry.
                    credit_d[g_q] = credit_dec;
                    ptr_d         = (credit_dec == '0) ? wrap_inc(g_q) : g_q;
                    state_d       = ST_IDLE;
                end else if (abort) begin
                    credit_d[g_q] = '0;
                    ptr_d         = wrap_inc(g_q);
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ms_en_d = (state_d == ST_GRANT) ? (NUM_MS'(1) << g_d) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            ms_en_q <= '0;
            for (int k = 0; k < NUM_MS; k++) begin
                credit_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            ptr_q    <= ptr_d;
            ms_en_q  <= ms_en_d;
            credit_q <= credit_d;
        end
    end

`ifdef SC_WRR_ARB_TIMEOUT_EN
    // to_cnt_q holds the number of ack-less grant cycles already elapsed, so
    // the current cycle is the limit cycle when it equals TO_CYCLES-1.
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       timeout_q;

    always_comb begin
        to_hit = (state_q == ST_GRANT) && !i_sl_ack && (to_cnt_q == 8'(TO_CYCLES - 1));
        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else if (!i_sl_ack) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= to_hit;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_ms_en    = ms_en_q;
    assign o_grant_id = g_q;
    assign o_busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_sc_wrr_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sc_wrr_slave_arbiter
//
// Directed bench for sc_wrr_slave_arbiter. A behavioural model (ptr, per-master
// credit, current grant) tracks the expected outputs and is compared with the
// DUT on every falling edge. Grant sequences are logged and compared against
// hand-derived literal orderings. The watchdog scenario is built only when
// SC_WRR_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sc_wrr_slave_arbiter;

    localparam int N     = 4;
    localparam int WW    = 3;
    localparam int IDW   = 2;
    localparam int TB_TO = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          i_reset;
    logic [N-1:0]  req;
    logic [N*WW-1:0] wts;
    logic          ack;
    logic [N-1:0]  o_ms_en;
    logic [IDW-1:0] o_grant_id;
    logic          o_busy;
    logic          o_timeout;

    always #5 clk = ~clk;

    sc_wrr_slave_arbiter #(
        .NUM_MS    (N),
        .WEIGHT_W  (WW),
        .TO_CYCLES (TB_TO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_ms_req    (req),
        .i_ms_weight (wts),
        .i_sl_ack    (ack),
        .o_ms_en     (o_ms_en),
        .o_grant_id  (o_grant_id),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    // ---------------- scoreboard state ----------------
    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [IDW-1:0] exp_q[$];
    logic [IDW-1:0] got_q[$];
    logic prev_busy = 1'b0;
    int   to_pulses = 0;
    bit   auto_ack  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, 32'(got_q.size() >= exp_q.size()), 32'd1);
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                chk(name, 32'(got_q[i]), 32'(exp_q[i]));
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy = 1'b0;
    int m_g    = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    bit m_to   = 1'b0;
    int m_credit [N] = '{default: 0};

    function automatic int weight_of(input int k);
        int w;
        w = int'(wts[k*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    // Advance the model by one rising edge using the inputs that edge samples.
    task automatic model_step();
        bit expired;
        m_to = 1'b0;
        if (i_reset) begin
            m_busy = 1'b0;
            m_g    = 0;
            m_ptr  = 0;
            m_cnt  = 0;
            foreach (m_credit[k]) m_credit[k] = 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (req[(m_ptr + i) % N]) begin
                        m_g = (m_ptr + i) % N;
                        break;
                    end
                end
                if (m_credit[m_g] == 0) m_credit[m_g] = weight_of(m_g);
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (ack) begin
            m_credit[m_g] = m_credit[m_g] - 1;
            m_ptr  = (m_credit[m_g] == 0) ? (m_g + 1) % N : m_g;
            m_busy = 1'b0;
        end else begin
            expired = 1'b0;
`ifdef SC_WRR_ARB_TIMEOUT_EN
            m_cnt   = m_cnt + 1;
            expired = (m_cnt >= TB_TO);
`endif
            if (!req[m_g] || expired) begin
                m_credit[m_g] = 0;
                m_ptr  = (m_g + 1) % N;
                m_busy = 1'b0;
                m_to   = expired;
            end
        end
    endtask

    // Compare on the falling edge, then advance the model: inputs are stable
    // here and are exactly what the next rising edge will sample.
    always @(negedge clk) begin
        logic [N-1:0] exp_en;
        exp_en = m_busy ? (N'(1) << m_g) : '0;
        chk("ms_en", 32'(o_ms_en), 32'(exp_en));
        chk("busy", 32'(o_busy), 32'(m_busy));
        chk("timeout", 32'(o_timeout), 32'(m_to));
        if (m_busy) chk("grant_id", 32'(o_grant_id), 32'(m_g));
        if (o_busy && !prev_busy) got_q.push_back(o_grant_id);
        prev_busy = o_busy;
        if (o_timeout) to_pulses++;
        model_step();
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ack) ack = o_busy;
    endtask

    task automatic wait_busy(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_busy) return;
        end
        total_cnt++;
        $display("FAIL %s: no grant within %0d cycles", name, budget);
    endtask

    task automatic do_reset();
        i_reset  = 1'b1;
        req      = '0;
        ack      = 1'b0;
        auto_ack = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        got_q.delete();
    endtask

    function automatic logic [N*WW-1:0] mk_w(input int w0, input int w1, input int w2, input int w3);
        return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        i_reset = 1'b1;
        req     = '0;
        ack     = 1'b0;
        wts     = mk_w(1, 1, 1, 1);

        // All weights 1, all requesting, immediate ack: plain rotation.
        do_reset();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_en", 32'(o_ms_en), 32'd0);
        chk("rst_id", 32'(o_grant_id), 32'd0);
        chk("rst_to", 32'(o_timeout), 32'd0);
        req = 4'b1111;
        auto_ack = 1'b1;
        repeat (11) tick();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        check_seq("rr_w1");

        // Zero weights behave as weight 1.
        wts = mk_w(0, 0, 0, 0);
        do_reset();
        req = 4'b1111;
        auto_ack = 1'b1;
        repeat (9) tick();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        check_seq("rr_w0");

        // Weight 3 on master 1 against weight 1 on master 2.
        wts = mk_w(1, 3, 1, 1);
        do_reset();
        req = 4'b0110;
        auto_ack = 1'b1;
        repeat (17) tick();
        exp_q = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2};
        check_seq("wrr_w3");

        // Ack in IDLE with nothing requesting changes nothing.
        wts = mk_w(1, 1, 1, 1);
        do_reset();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (3) tick();
        chk("idle_ack_busy", 32'(o_busy), 32'd0);
        chk("idle_ack_grants", 32'(got_q.size()), 32'd0);

        // Request drop aborts the grant; master 0 later gets a fresh weight.
        wts = mk_w(2, 1, 1, 1);
        do_reset();
        req = 4'b0001;
        wait_busy("drop_first", 10);
        req = 4'b0010;
        tick();
        chk("drop_en", 32'(o_ms_en), 32'd0);
        wait_busy("drop_next", 10);
        auto_ack = 1'b1;
        ack = 1'b1;
        req = 4'b0011;
        repeat (8) tick();
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
        check_seq("drop_seq");

        // Reset mid-burst while master 1 holds credit 2.
        wts = mk_w(1, 3, 1, 1);
        do_reset();
        req = 4'b0010;
        auto_ack = 1'b1;
        wait_busy("rst_mid_g1", 10);
        tick();
        wait_busy("rst_mid_g2", 10);
        i_reset = 1'b1;
        tick();
        chk("rst_mid_en", 32'(o_ms_en), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        got_q.delete();
        req = 4'b0110;
        repeat (10) tick();
        exp_q = '{2'd1, 2'd1, 2'd1, 2'd2};
        check_seq("rst_mid_seq");

`ifdef SC_WRR_ARB_TIMEOUT_EN
        // Watchdog: no ack for TB_TO cycles releases master 2, then ack in
        // the limit cycle beats the watchdog.
        wts = mk_w(1, 1, 1, 1);
        do_reset();
        to_pulses = 0;
        req = 4'b0100;
        wait_busy("to_grant", 10);
        repeat (TB_TO - 1) tick();
        chk("to_hold_busy", 32'(o_busy), 32'd1);
        tick();
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_release", 32'(o_busy), 32'd0);
        req = 4'b1100;
        wait_busy("to_next", 10);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        req = 4'b0100;
        wait_busy("to_again", 10);
        repeat (TB_TO - 1) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("to_ack_wins", 32'(o_timeout), 32'd0);
        chk("to_ack_release", 32'(o_busy), 32'd0);
        req = 4'b0000;
        repeat (2) tick();
        exp_q = '{2'd2, 2'd3, 2'd2};
        check_seq("to_seq");
        chk("to_pulse_count", 32'(to_pulses), 32'd1);
`endif

        req = '0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard stop in case a task sequence stalls unexpectedly.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/sc_wrr_slave_arbiter.md
# sc_wrr_slave_arbiter

Weighted round-robin arbiter for one shared slave port of the single-cycle crossbar. Sits in front of each slave and grants exactly one of NUM_MS masters at a time. Holds the grant until the slave acknowledges. Lets a master issue up to its configured weight of consecutive transactions before priority rotates. An optional watchdog releases a grant the slave never acknowledges.

## Interface
Parameters:
- NUM_MS, 4, number of requesting masters (>= 2)
- WEIGHT_W, 3, width of each per-master weight field
- TO_CYCLES, 255, watchdog limit in cycles; used only with the macro defined; 8-bit counter, range 1..255

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_ms_req  in  NUM_MS  per-master request, level; must stay high until the master sees its grant end
- i_ms_weight  in  NUM_MS*WEIGHT_W  per-master weight, master k at bits [k*WEIGHT_W +: WEIGHT_W]; quasi-static; 0 treated as 1
- i_sl_ack  in  1  slave completion strobe for the current grant
- o_ms_en  out  NUM_MS  one-hot grant, registered
- o_grant_id  out  clog2(NUM_MS)  index of granted master, valid while o_busy
- o_busy  out  1  a grant is active
- o_timeout  out  1  one-cycle pulse on watchdog release; constant 0 without the macro

## Operation
- State: FSM {IDLE, GRANT}, rotation pointer ptr, per-master credit counters credit[k] (WEIGHT_W bits), and in GRANT the current master g.
- IDLE:
  - If any i_ms_req is high, select the first requesting master scanning ptr, ptr+1, … with modulo-NUM_MS wrap.
  - Go to GRANT with g = selection.
  - If credit[g] == 0, load credit[g] = max(weight[g], 1).
- GRANT:
  - o_ms_en = one-hot(g), o_grant_id = g, o_busy = 1.
  - i_sl_ack high: credit[g] decrements, then return to IDLE.
  - If the decremented credit is 0, ptr = g+1 mod NUM_MS. Otherwise ptr = g, so g wins the next arbitration if it is still requesting.
- Request drop: if i_ms_req[g] falls while in GRANT and no ack arrives that cycle, the grant is aborted:
  - return to IDLE, credit[g] = 0, ptr = g+1.
  - If ack and drop occur in the same cycle, the ack rule applies.
- Non-granted masters: credits are untouched.
- i_sl_ack is ignored in IDLE.
- Weights are read only at credit reload. Changing a weight mid-burst takes effect at the next reload.

## Timing
- Reset state: IDLE, ptr = 0, all credits 0, o_ms_en = 0, o_grant_id = 0, o_busy = 0, o_timeout = 0.
- Reset asserted mid-grant clears the grant on the next edge.
- Grant latency: o_ms_en asserts the cycle after the request is sampled in IDLE (1 cycle).
- Release: o_ms_en deasserts the cycle after the ack (or drop) is sampled.
- Every grant is followed by at least one IDLE cycle, so the minimum grant-to-grant period is 2 cycles with ack on the first GRANT cycle.
- Simultaneous requests: resolved purely by ptr order. No master waits more than (NUM_MS-1) bursts.

## Configuration
- SC_WRR_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering GRANT and increments each GRANT cycle without ack.
  - When it reaches TO_CYCLES, the grant is released as an abort (credit[g] = 0, ptr = g+1), and o_timeout pulses high for exactly the release cycle.
  - An ack in the limit cycle takes priority: no timeout.
- Not defined:
  - No counter; o_timeout tied 0.
  - A grant is held indefinitely until ack or request drop.

## Test plan
- Reset, all weights 1, i_ms_req=4'b1111, ack on every first GRANT cycle -> grants in order 0,1,2,3,0; each grant lasts 1 cycle, with 1 IDLE cycle between grants.
- Weight[1]=3, others 1, masters 1 and 2 continuously requesting, immediate acks -> grant sequence 1,1,1,2,1,1,1,2.
- Master 0 granted, drops i_ms_req[0] before ack -> o_ms_en clears next cycle, ptr=1, credit[0]=0; a later request from 0 gets a fresh weight load.
- Ack pulsed in IDLE with no requests -> no state change; o_busy stays 0.
- Macro on, TO_CYCLES=4, master 2 granted, no ack -> o_timeout high for 1 cycle after 4 GRANT cycles, grant released, next arbitration starts at master 3; repeat with ack in cycle 4 -> no timeout.
- Assert i_reset during a GRANT with credit[1]=2 -> next cycle o_ms_en=0, ptr=0, all credits 0.
